pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It merges stall requests from ID and EX, detects load-use hazards between ID and EX, and sequences multi-cycle divide operations with a timeout watchdog. It drives a one-hot-prefix stall vector to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and a flush strobe. It sits beside the datapath and is instantiated once at the core top level.

## Interface
Parameters:
- DIV_TIMEOUT, 40: maximum BUSY cycles allowed before the divide is aborted; legal range 2..255.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stallreq_id  in  1  ID-stage stall request
- stallreq_ex  in  1  EX-stage stall request
- id_reg1_re  in  1  ID reads source operand 1 from the register file
- id_raddr1  in  5  ID source operand 1 address
- id_reg2_re  in  1  ID reads source operand 2 from the register file
- id_raddr2  in  5  ID source operand 2 address
- ex_is_load  in  1  instruction in EX is a load
- ex_we  in  1  instruction in EX writes the register file
- ex_waddr  in  5  EX destination register
- div_start  in  1  EX issues a divide; sampled only in IDLE
- div_done  in  1  divider result valid, one-cycle pulse
- flush_req  in  1  branch/exception flush request
- stall_o  out  6  bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; a set bit holds that stage
- flush_o  out  1  clear the IF/ID and ID/EX registers
- div_busy_o  out  1  divide in progress (state BUSY)
- div_abort_o  out  1  one-cycle pulse: the divider must discard its operation
- stall_cycles_o  out  32  performance counter (see Configuration)

## Operation
- Load-use hazard: `ex_is_load & ex_we & ex_waddr != 0 & ((id_reg1_re & id_raddr1 == ex_waddr) | (id_reg2_re & id_raddr2 == ex_waddr))`. A hazard is treated as an ID stall request.
- Divide FSM states are IDLE, BUSY and ABORT.
  - IDLE to BUSY on `div_start`; the cycle counter loads 0.
  - In BUSY the counter increments each cycle.
  - BUSY to IDLE on `div_done`.
  - BUSY to ABORT when the counter equals DIV_TIMEOUT-1 without `div_done`.
  - BUSY to ABORT on `flush_req`. `flush_req` has priority over `div_done` in the same cycle.
  - ABORT to IDLE unconditionally.
  - `div_abort_o` = (state == ABORT).
- Divide stall: asserted when (state == IDLE & `div_start`) or (state == BUSY & `!div_done`). It is treated as an EX stall request.
- Stall vector priority, highest first:
  - `flush_req`: stall_o = 000000, flush_o = 1.
  - Any EX-level request: 001111.
  - Any ID-level request: 000111.
  - Otherwise: 000000.
- `flush_o` = `flush_req`.

## Timing
- `stall_o`, `flush_o`: combinational, same cycle as the inputs; there is no registered path from input to output.
- `div_busy_o`, `div_abort_o`: decoded from registered state.
- Divide latency seen by EX: stall held from the `div_start` cycle through the cycle before `div_done`; released in the `div_done` cycle.
- Timeout: with no `div_done`, the FSM enters ABORT on the DIV_TIMEOUT-th BUSY cycle. `div_abort_o` is high for exactly one cycle, and the stall is released in that cycle.
- `div_start` during BUSY or ABORT is ignored.
- Reset values: state IDLE, counter 0, stall_cycles_o 0, div_busy_o 0, div_abort_o 0. stall_o and flush_o are 0 as long as no inputs are asserted.
- Reset asserted mid-divide returns the FSM to IDLE immediately; no abort pulse is produced.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: stall_cycles_o increments on every cycle with stall_o[0] = 1. It saturates at 0xFFFFFFFF and clears only on reset.
- `PIPE_CTRL_PERF_EN` undefined: the counter is not built and stall_cycles_o is tied to 0.

## Structure
- Shared definitions header holds:
  - stall-vector bit indices and the encodings 000111 and 001111;
  - FSM state encodings (2 bits: IDLE = 00, BUSY = 01, ABORT = 10);
  - the NOP register address (0) used in the hazard compare.
- Sub-module `pipe_div_seq` contains the divide FSM, timeout counter, busy/abort decode and divide-stall output. `pipe_ctrl` holds the hazard compare, priority mux and performance counter.

## Test plan
- Load-use: ex_is_load = 1, ex_we = 1, ex_waddr = 5, id_reg1_re = 1, id_raddr1 = 5 → stall_o = 000111. The same stimulus with ex_waddr = 0 → stall_o = 000000.
- Divide normal: div_start pulse, div_done 10 cycles later → stall_o = 001111 for 10 cycles, then 0; div_busy_o high for 10 cycles; no div_abort_o.
- Timeout: div_start with no div_done, DIV_TIMEOUT = 40 → one div_abort_o pulse on the 40th BUSY cycle, stall released in that cycle, FSM back in IDLE.
- Flush in BUSY: flush_req and div_done in the same cycle → stall_o = 0, flush_o = 1; div_abort_o pulses the next cycle.
- Reset mid-divide: rst asserted in BUSY → div_busy_o = 0 asynchronously, stall_cycles_o = 0, no abort pulse after release.
- Performance counter (with `PIPE_CTRL_PERF_EN`): 7 stall cycles → stall_cycles_o = 7. Forced to 0xFFFFFFFF, then stalled → stays 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall-vector
// layout, divide-sequencer state encoding and the NOP register address.
package pipe_ctrl_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE   = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID_LVL = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_LVL = 6'b001111;

  localparam logic [4:0] NOP_ADDR = 5'd0;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_BUSY  = 2'b01,
    DIV_ABORT = 2'b10
  } div_state_e;

  // A source operand collides with a pending load destination.
  function automatic logic load_use_hit(
    input logic       is_load,
    input logic       we,
    input logic [4:0] waddr,
    input logic       re1,
    input logic [4:0] raddr1,
    input logic       re2,
    input logic [4:0] raddr2
  );
    return is_load & we & (waddr != NOP_ADDR) &
           ((re1 & (raddr1 == waddr)) | (re2 & (raddr2 == waddr)));
  endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// Multi-cycle divide sequencer: IDLE/BUSY/ABORT FSM with a timeout watchdog
// that aborts the operation after DIV_TIMEOUT BUSY cycles.
module pipe_div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  input  logic div_done,
  input  logic flush_req,
  output logic div_busy_o,
  output logic div_abort_o,
  output logic div_stall_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(DIV_TIMEOUT - 1);

  div_state_e r_state;
  logic [7:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (div_start) begin
            r_state <= DIV_BUSY;
            r_cnt   <= '0;
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          // A flush kills the divide even if its result lands this cycle.
          if (flush_req)                   r_state <= DIV_ABORT;
          else if (div_done)               r_state <= DIV_IDLE;
          else if (r_cnt == TIMEOUT_LAST)  r_state <= DIV_ABORT;
        end
        DIV_ABORT: r_state <= DIV_IDLE;
        default:   r_state <= DIV_IDLE;
      endcase
    end
  end

  assign div_busy_o  = (r_state == DIV_BUSY);
  assign div_abort_o = (r_state == DIV_ABORT);
  assign div_stall_o = ((r_state == DIV_IDLE) & div_start) |
                       ((r_state == DIV_BUSY) & ~div_done);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use detection, stall priority mux and
// optional stall-cycle counter (enabled by `PIPE_CTRL_PERF_EN).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               id_reg1_re,
  input  logic [4:0]         id_raddr1,
  input  logic               id_reg2_re,
  input  logic [4:0]         id_raddr2,
  input  logic               ex_is_load,
  input  logic               ex_we,
  input  logic [4:0]         ex_waddr,
  input  logic               div_start,
  input  logic               div_done,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               div_busy_o,
  output logic               div_abort_o,
  output logic [31:0]        stall_cycles_o
);

  logic w_hazard;
  logic w_div_stall;
  logic w_ex_req;
  logic w_id_req;

  pipe_div_seq #(
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_div_seq (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_done    (div_done),
    .flush_req   (flush_req),
    .div_busy_o  (div_busy_o),
    .div_abort_o (div_abort_o),
    .div_stall_o (w_div_stall)
  );

  assign w_hazard = load_use_hit(ex_is_load, ex_we, ex_waddr,
                                 id_reg1_re, id_raddr1, id_reg2_re, id_raddr2);
  assign w_ex_req = stallreq_ex | w_div_stall;
  assign w_id_req = stallreq_id | w_hazard;

  // NOTE: stall_o gets a default before the priority chain so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stall_o = STALL_NONE;
    if (flush_req)     stall_o = STALL_NONE;
    else if (w_ex_req) stall_o = STALL_EX_LVL;
    else if (w_id_req) stall_o = STALL_ID_LVL;
  end

  assign flush_o = flush_req;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (stall_o[STALL_PC] && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (DIV_TIMEOUT = 40); the stall
// counter checks follow `PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex;
  logic        id_reg1_re, id_reg2_re;
  logic [4:0]  id_raddr1, id_raddr2;
  logic        ex_is_load, ex_we;
  logic [4:0]  ex_waddr;
  logic        div_start, div_done, flush_req;
  logic [5:0]  stall_o;
  logic        flush_o, div_busy_o, div_abort_o;
  logic [31:0] stall_cycles_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .id_reg1_re     (id_reg1_re),
    .id_raddr1      (id_raddr1),
    .id_reg2_re     (id_reg2_re),
    .id_raddr2      (id_raddr2),
    .ex_is_load     (ex_is_load),
    .ex_we          (ex_we),
    .ex_waddr       (ex_waddr),
    .div_start      (div_start),
    .div_done       (div_done),
    .flush_req      (flush_req),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .div_busy_o     (div_busy_o),
    .div_abort_o    (div_abort_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; stallreq_ex = 0;
    id_reg1_re = 0; id_raddr1 = 0; id_reg2_re = 0; id_raddr2 = 0;
    ex_is_load = 0; ex_we = 0; ex_waddr = 0;
    div_start = 0; div_done = 0; flush_req = 0;
  endtask

  int busy_cnt, stall_cnt, abort_cnt, abort_stall;
  logic abort_seen;

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_busy", 32'(div_busy_o), 32'h0);
    check("rst_abort", 32'(div_abort_o), 32'h0);
    check("rst_perf", stall_cycles_o, 32'h0);
    rst = 1'b0;
    tick();

    // Load-use hazards and stall priority (all combinational)
    ex_is_load = 1; ex_we = 1; ex_waddr = 5; id_reg1_re = 1; id_raddr1 = 5; #1;
    check("lu_rs1", 32'(stall_o), 32'b000111);
    ex_waddr = 0; id_raddr1 = 0; #1;
    check("lu_x0", 32'(stall_o), 32'b000000);
    ex_waddr = 9; id_reg1_re = 0; id_raddr1 = 9; #1;
    check("lu_re_off", 32'(stall_o), 32'b000000);
    id_reg2_re = 1; id_raddr2 = 9; #1;
    check("lu_rs2", 32'(stall_o), 32'b000111);
    ex_we = 0; #1;
    check("lu_no_we", 32'(stall_o), 32'b000000);
    ex_we = 1; ex_is_load = 0; #1;
    check("lu_no_load", 32'(stall_o), 32'b000000);
    clear_inputs(); stallreq_id = 1; stallreq_ex = 1; #1;
    check("ex_over_id", 32'(stall_o), 32'b001111);
    flush_req = 1; #1;
    check("flush_prio", 32'(stall_o), 32'b000000);
    check("flush_o", 32'(flush_o), 32'h1);
    clear_inputs(); #1;
    check("idle_stall", 32'(stall_o), 32'b000000);
    tick();

    // Normal divide: done arrives 10 cycles after start
    busy_cnt = 0; stall_cnt = 0; abort_cnt = 0;
    div_start = 1; #1;
    if (stall_o == 6'b001111) stall_cnt++;
    tick();
    div_start = 0;
    for (int k = 1; k <= 10; k++) begin
      div_done = (k == 10); #1;
      if (stall_o == 6'b001111) stall_cnt++;
      if (div_busy_o) busy_cnt++;
      if (div_abort_o) abort_cnt++;
      tick();
    end
    div_done = 0; #1;
    check("div_stall_cycles", 32'(stall_cnt), 32'd10);
    check("div_busy_cycles", 32'(busy_cnt), 32'd10);
    check("div_no_abort", 32'(abort_cnt + int'(div_abort_o)), 32'd0);
    check("div_idle_busy", 32'(div_busy_o), 32'h0);
    check("div_idle_stall", 32'(stall_o), 32'h0);
    tick();

    // Timeout: no done; div_start held high through BUSY/ABORT must be ignored
    busy_cnt = 0; abort_seen = 0; abort_stall = -1;
    div_start = 1; tick();
    for (int k = 0; k < 60 && !abort_seen; k++) begin
      #1;
      if (div_busy_o) busy_cnt++;
      if (div_abort_o) begin
        abort_seen = 1;
        abort_stall = int'(stall_o);
      end
      tick();
    end
    div_start = 0; #1;
    check("to_abort_seen", 32'(abort_seen), 32'h1);
    check("to_busy_cycles", 32'(busy_cnt), 32'd40);
    check("to_abort_stall", 32'(abort_stall), 32'h0);
    check("to_abort_pulse", 32'(div_abort_o), 32'h0);
    check("to_back_idle", 32'(div_busy_o), 32'h0);
    tick();

    // Flush and done together in BUSY
    div_start = 1; tick();
    div_start = 0; tick();
    flush_req = 1; div_done = 1; #1;
    check("fl_stall", 32'(stall_o), 32'h0);
    check("fl_flush_o", 32'(flush_o), 32'h1);
    check("fl_busy", 32'(div_busy_o), 32'h1);
    tick();
    flush_req = 0; div_done = 0; #1;
    check("fl_abort", 32'(div_abort_o), 32'h1);
    check("fl_abort_busy", 32'(div_busy_o), 32'h0);
    tick(); #1;
    check("fl_abort_end", 32'(div_abort_o), 32'h0);

    // Reset in the middle of a divide
    div_start = 1; tick();
    div_start = 0; tick();
    rst = 1; #1;
    check("rs_busy", 32'(div_busy_o), 32'h0);
    check("rs_perf", stall_cycles_o, 32'h0);
    #3; rst = 0;
    abort_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (div_abort_o || div_busy_o) abort_cnt++;
    end
    check("rs_no_abort", 32'(abort_cnt), 32'h0);

    // Stall-cycle counter
    stallreq_id = 1;
    for (int k = 0; k < 7; k++) tick();
    stallreq_id = 0; #1;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_7", stall_cycles_o, 32'd7);
    force dut.r_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cycles;
    stallreq_ex = 1;
    tick(); tick();
    stallreq_ex = 0; #1;
    check("perf_sat", stall_cycles_o, 32'hFFFF_FFFF);
`else
    check("perf_off", stall_cycles_o, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
